program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the program-memory interface: the CPU fetches opcodes from program RAM, and this block fills that RAM before the CPU runs.
- Accepts a framed byte stream on a valid/ready input, writes payload bytes to consecutive RAM addresses, verifies a checksum, then releases the CPU.
- Sits between the external input byte port / switch and the program RAM write port. Drives the CPU hold line.

Parameters:
- ADDR_W, 8, program RAM address width.
- BASE_ADDR, 0, first address written.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, max idle cycles between bytes inside a frame before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-high reset
- start  in  1  level from the switch; a rising edge arms the loader
- in_valid  in  1  input byte present
- in_data  in  8  input byte
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  program RAM write strobe
- mem_addr  out  ADDR_W  program RAM write address
- mem_wdata  out  8  program RAM write data
- cpu_hold  out  1  holds the CPU (PC/registers frozen) while high
- load_done  out  1  frame loaded and checksum OK (sticky)
- load_error  out  1  sync, length, checksum or timeout fault (sticky)
- monitor  out  8  {state[2:0], 1'b0, bytes_remaining[3:0]} for debug

Behaviour:
- Reset values:
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0.
  - State=IDLE.
  - The CPU stays held until a good load completes.
- A byte is accepted when in_valid & in_ready are both high at a clk edge.
- in_ready=1 in SYNC, LEN, DATA and CHK; 0 elsewhere.
- States:
  - IDLE: wait for a start rising edge (edge detected from start registered at clk). Then clear load_done and load_error, set cpu_hold=1, go to SYNC.
  - SYNC: an accepted byte equal to SYNC_BYTE goes to LEN. Any other byte is discarded and the block stays in SYNC; no error is raised and the timeout is not armed.
  - LEN: the accepted byte is N. N=0 → ERR. If N > 2^ADDR_W − BASE_ADDR → ERR. Otherwise load the count with N, clear the checksum accumulator, go to DATA.
  - DATA:
    - Each accepted byte is registered onto mem_wdata and mem_addr; mem_we pulses high for exactly one cycle, in the cycle after acceptance (1-cycle write latency).
    - The address increments by 1 after each write. The count decrements. The accumulator adds the byte modulo 256.
    - When the count reaches 0, go to CHK.
  - CHK:
    - Accepted byte C. If (sum + C) mod 256 == 0 → DONE, else → ERR.
    - No RAM write is made for C.
  - DONE: load_done=1, cpu_hold=0. A new start rising edge re-enters SYNC with cpu_hold=1 and mem_addr=BASE_ADDR.
  - ERR: load_error=1, cpu_hold stays 1. Only a new start rising edge or res leaves ERR.
- Timeout: in LEN, DATA and CHK an idle counter increments on each cycle with no accepted byte and clears on each accept. Reaching TIMEOUT → ERR.
- Simultaneous events:
  - A start rising edge during SYNC, LEN, DATA or CHK restarts the frame: mem_addr returns to BASE_ADDR and the state goes to SYNC.
  - A byte accepted in that same cycle is discarded.
  - A pending mem_we from the prior cycle still completes.
- res mid-frame: all state is cleared immediately; cpu_hold=1. RAM contents are not erased; a partial program stays in RAM but is never released.
- The last data write (mem_we) completes before or in the same cycle as entry to CHK. cpu_hold falls only in DONE, never while mem_we is high.

Decomposition:
- Shared package (cpu_pkg):
  - loader state enum (IDLE, SYNC, LEN, DATA, CHK, DONE, ERR; 3 bits)
  - SYNC_BYTE default
  - the monitor field layout
- One natural sub-module, loader_timeout: a loadable idle counter with clear/enable/expire. Everything else stays in one FSM.

Test Plan:
- Good frame: start edge; stream A5,03,11,22,33,9A → writes 11@0, 22@1, 33@2, one mem_we pulse per byte; then load_done=1, cpu_hold=0, load_error=0.
- Bad checksum: A5,02,01,02,00 → two writes; then load_error=1, cpu_hold=1, load_done=0.
- Garbage before sync: 00,FF,A5,01,7E,82 → garbage ignored, single write 7E@0; then done.
- Length faults:
  - A5,00 → error.
  - With BASE_ADDR=250: A5,07 → error, no mem_we.
- Timeout with TIMEOUT=4: A5,02,10, then in_valid low for 4 cycles → load_error=1. A new start edge plus a good frame → done.
- Reset mid-DATA: res asserted after 2 of 5 bytes → all outputs at reset values and cpu_hold=1 immediately (asynchronous); no further mem_we.
- Restart mid-frame: start edge during DATA → mem_addr=BASE_ADDR, state SYNC.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader state codes, default sync marker and monitor layout {state[2:0], rsvd, remaining[3:0]}
package program_loader_pkg;
  localparam logic [2:0] S_IDLE = 3'd0, S_SYNC = 3'd1, S_LEN = 3'd2, S_DATA = 3'd3, S_CHK = 3'd4, S_DONE = 3'd5, S_ERR = 3'd6;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  typedef struct packed {
    logic [2:0] state;
    logic       rsvd;
    logic [3:0] remaining;
  } monitor_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in (in_valid/in_data/in_ready) and program RAM write port (mem_we/mem_addr/mem_wdata); master = host side, slave = loader
interface program_loader_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  modport master(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/program_loader_timeout.sv
// program_loader_timeout: idle counter (clk, rst, clr, en) raising expire on the LIMIT-th enabled cycle; LIMIT=0 never expires
module program_loader_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt;
  assign expire = (LIMIT != 0) && en && (cnt == 16'(LIMIT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 16'd1;
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte loader (clk, res, start, bus slave) filling program RAM, checking checksum, driving cpu_hold/load_done/load_error/monitor
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_error,
  output logic [7:0]       monitor
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam int ROOM = (1 << ADDR_W) - BASE_ADDR;
  logic [2:0] state;
  logic start_q, start_rise, in_frame, acc, expire;
  logic [7:0] rem, sum;
  logic [ADDR_W-1:0] ptr;
  assign start_rise = start & ~start_q;
  assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign bus.in_ready = (state == S_SYNC) || in_frame;
  assign acc = bus.in_valid & bus.in_ready;
  assign cpu_hold = state != S_DONE;
  assign load_done = state == S_DONE;
  assign load_error = state == S_ERR;
  assign monitor = monitor_t'{state, 1'b0, rem[3:0]};
  program_loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(res),
    .clr(!in_frame || acc || start_rise),
    .en(in_frame && !acc),
    .expire(expire)
  );
  always_ff @(posedge clk or posedge res)
    if (res) begin
      state <= S_IDLE;
      start_q <= 1'b0;
      rem <= '0;
      sum <= '0;
      ptr <= BASE;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= BASE;
      bus.mem_wdata <= '0;
    end else begin
      start_q <= start;
      bus.mem_we <= 1'b0;
      if (start_rise) begin
        state <= S_SYNC;
        ptr <= BASE;
        bus.mem_addr <= BASE;
      end else if (expire) state <= S_ERR;
      else if (acc)
        case (state)
          S_SYNC: if (bus.in_data == SYNC_BYTE) state <= S_LEN;
          S_LEN:
            if (bus.in_data == 8'd0 || int'(bus.in_data) > ROOM) state <= S_ERR;
            else begin
              rem <= bus.in_data;
              sum <= '0;
              state <= S_DATA;
            end
          S_DATA: begin
            bus.mem_we <= 1'b1;
            bus.mem_wdata <= bus.in_data;
            bus.mem_addr <= ptr;
            ptr <= ptr + ADDR_W'(1);
            sum <= sum + bus.in_data;
            rem <= rem - 8'd1;
            if (rem == 8'd1) state <= S_CHK;
          end
          S_CHK: state <= (sum + bus.in_data == 8'd0) ? S_DONE : S_ERR;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader with a frame-level reference model
module tb_program_loader;
  import program_loader_pkg::*;
  localparam int BASE = 250;
  localparam int ROOM = 256 - BASE;
  localparam logic [7:0] SB = 8'hA5;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, res = 1'b1, start = 1'b0;
  logic cpu_hold, load_done, load_error, prev_end = 1'b0;
  logic [7:0] monitor;
  int checks = 0, errors = 0;
  logic [15:0] wq[$];
  logic [2:0] oq[$];
  program_loader_if #(.ADDR_W(8)) bus();
  program_loader #(.ADDR_W(8), .BASE_ADDR(BASE), .SYNC_BYTE(SB), .TIMEOUT(4)) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error),
    .monitor(monitor)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (wq.size() == 0) check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
      else check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, 32'(wq.pop_front()));
      check("hold_during_write", cpu_hold, 1);
    end
    if ((load_done | load_error) && !prev_end) begin
      if (oq.size() == 0) check("unexpected_end", {load_done, load_error, cpu_hold}, 32'hFFFF_FFFF);
      else check("outcome_done_err_hold", {load_done, load_error, cpu_hold}, 32'(oq.pop_front()));
    end
    prev_end <= load_done | load_error;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    int g = $urandom_range(0, 2);
    repeat (g) tick();
    check("in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data = v;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_end();
    int t = 0;
    while (!(load_done | load_error) && t < 20) begin
      tick();
      t++;
    end
    check("frame_end_within_budget", t < 20, 1);
    repeat (2) tick();
  endtask
  task automatic run_frame(input bq_t b);
    int i = 0, n, s = 0;
    while (i < b.size() && b[i] != SB) i++;
    n = int'(b[i+1]);
    if (n == 0 || n > ROOM) oq.push_back(3'b011);
    else begin
      for (int k = 0; k < n; k++) begin
        wq.push_back({8'(BASE + k), b[i+2+k]});
        s += int'(b[i+2+k]);
      end
      oq.push_back(((s + int'(b[i+2+n])) % 256 == 0) ? 3'b100 : 3'b011);
    end
    pulse_start();
    foreach (b[j]) send_byte(b[j]);
    wait_end();
  endtask
  task automatic rand_frame();
    bq_t b;
    int n, s = 0;
    logic [7:0] g, c;
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom_range(0, 255));
      b.push_back(g == SB ? 8'h00 : g);
    end
    b.push_back(SB);
    n = $urandom_range(0, 7);
    b.push_back(8'(n));
    if (n >= 1 && n <= ROOM) begin
      for (int k = 0; k < n; k++) begin
        g = 8'($urandom_range(0, 255));
        b.push_back(g);
        s += int'(g);
      end
      c = 8'(0 - s);
      if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
      b.push_back(c);
    end
    run_frame(b);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, BASE);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_monitor", monitor, 0);
    res = 1'b0;
    repeat (3) tick();
    check("idle_hold", cpu_hold, 1);
    check("idle_ready", bus.in_ready, 0);
    run_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A});
    check("done_ready", bus.in_ready, 0);
    run_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00});
    run_frame('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h82});
    run_frame('{8'hA5, 8'h00});
    run_frame('{8'hA5, 8'h07});
    run_frame('{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hEB});
    pulse_start();
    wq.push_back({8'(BASE), 8'h10});
    oq.push_back(3'b011);
    send_byte(SB);
    send_byte(8'h02);
    send_byte(8'h10);
    repeat (3) tick();
    check("timeout_not_early", load_error, 0);
    tick();
    check("timeout_fires", load_error, 1);
    repeat (2) tick();
    run_frame('{8'hA5, 8'h02, 8'h40, 8'h80, 8'h40});
    pulse_start();
    wq.push_back({8'(BASE), 8'h21});
    wq.push_back({8'(BASE + 1), 8'h42});
    send_byte(SB);
    send_byte(8'h05);
    send_byte(8'h21);
    send_byte(8'h42);
    @(negedge clk);
    #2 res = 1'b1;
    #1;
    check("async_rst_hold", cpu_hold, 1);
    check("async_rst_we", bus.mem_we, 0);
    check("async_rst_addr", bus.mem_addr, BASE);
    check("async_rst_ready", bus.in_ready, 0);
    check("async_rst_monitor", monitor, 0);
    repeat (3) tick();
    res = 1'b0;
    repeat (4) tick();
    check("rst_writes_drained", wq.size(), 0);
    pulse_start();
    wq.push_back({8'(BASE), 8'h01});
    wq.push_back({8'(BASE + 1), 8'h02});
    send_byte(SB);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = SB;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("restart_state_sync", monitor[7:5], S_SYNC);
    check("restart_addr_base", bus.mem_addr, BASE);
    check("restart_hold", cpu_hold, 1);
    check("pending_write_done", wq.size(), 0);
    repeat (2) tick();
    run_frame('{8'hA5, 8'h01, 8'h55, 8'hAB});
    repeat (12) rand_frame();
    repeat (3) tick();
    check("writes_all_seen", wq.size(), 0);
    check("outcomes_all_seen", oq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
